bram_to_gddr6_writer: RTL and testbench
=======================================

// Module: bram_to_gddr6_writer
// PURPOSE
// - Reads N 256-bit words from a local BRAM and writes them to GDDR6 over the AXI4 write channels of an externally instantiated NAP.
// - Splits each transfer into INCR bursts that never cross a 4 KB boundary.
// - Write-side counterpart of the GDDR6-to-BRAM read path.
// - Single clock domain: control and status are already in the NAP clock domain; no CDC inside.
// PARAMETERS
// - MAX_BURST  16   max beats per AXI burst (1..16)
// - AXI_ID     8'h1 constant AWID for every burst
// PORTS
// - i_nap_clk      in   1    single clock (300-400 MHz)
// - i_nap_reset    in   1    asynchronous, active-high reset
// - i_start        in   1    1-cycle start pulse; ignored while o_busy
// - i_gddr_addr    in   28   GDDR6 byte address; [4:0] must be 0
// - i_bram_addr    in   9    first BRAM word
// - i_length       in   8    beats (256-bit words) to write; 0 = no-op
// - o_busy         out  1    transfer in progress
// - o_done         out  1    sticky: last transfer completed OKAY
// - o_error        out  1    sticky: a BRESP != OKAY was received
// - o_bram_rd_en   out  1    BRAM read strobe
// - o_bram_rd_addr out  9    BRAM read address
// - i_bram_rd_data in   256  read data, valid exactly 1 cycle after o_bram_rd_en
// - o_axi_aw{valid,addr[27:0],len[7:0],id[7:0],size[2:0],burst[1:0]}, i_axi_awready
// - o_axi_w{valid,data[255:0],strb[31:0],last}, i_axi_wready
// - i_axi_bvalid, o_axi_bready, i_axi_bresp[1:0], i_axi_bid[7:0]
// - o_axi_ar{valid,addr,len,id,size,burst}, o_axi_rready: tied to 0 (write-only)
// BEHAVIOUR
// - Reset: all outputs 0; FSM to ST_IDLE; done/error cleared. Reset mid-transfer abandons the AXI transaction immediately (no drain).
// - FSM states:
//   - ST_IDLE: on i_start, latch addr/bram/length, clear done/error. length==0 -> ST_FINISH; else -> ST_AW.
//   - ST_AW: compute blen = min(remaining, MAX_BURST, (4096 - addr[11:0]) >> 5).
//     - Drive awvalid=1, awaddr=cur_addr, awlen=blen-1, awsize=5, awburst=INCR, awid=AXI_ID.
//     - Hold all AW fields stable until awready; then -> ST_RD.
//   - ST_RD: rd_en=1 at cur_bram for one cycle -> ST_RDW.
//   - ST_RDW: capture i_bram_rd_data into the W register -> ST_W.
//   - ST_W: wvalid=1, wstrb=all 1s, wlast=(beat==blen-1). Hold wdata/wlast stable until wready.
//     - On handshake: cur_bram+1 (wraps mod 512), remaining-1. Last beat -> ST_B; else -> ST_RD.
//   - ST_B: bready=1. On bvalid: bresp!=0 -> set error, -> ST_IDLE (abort).
//     - Else cur_addr += blen*32; remaining>0 -> ST_AW, else -> ST_FINISH.
//   - ST_FINISH: set done -> ST_IDLE.
// - o_busy = state != ST_IDLE. Sustained rate is 1 beat per 3 cycles plus AW/B overhead; no performance target.
// - The AW handshake completes before the first W beat; the next burst's AW is issued only after its B. One outstanding burst.
// - awvalid never deasserts without a handshake (AXI rule). bid is not checked.
// - cur_addr wraps mod 2^28. Misaligned i_gddr_addr[4:0] is silently masked to 0.
// - i_start during busy: no effect. i_start in ST_FINISH's cycle: ignored.
// CONFIGURATION
// - GDDR6_WR_SUB42_EN defined: each 32-bit lane of the captured BRAM word is written as (lane - 32'd42), mod 2^32.
//   This is the inverse of the read path's +42 processing.
// - Not defined: data is passed through unmodified.
// - Latency and handshakes are identical in both builds.
// TESTING
// - len=1, addr=0x100, bram=5, BRAM[5]=0xAA..: one AW (len=0, size=5, INCR, id=1), one W (wlast=1, wstrb=FFFFFFFF); o_done=1, o_busy=0.
// - len=40, addr=0: three bursts awlen=15,15,7 at awaddr 0x000, 0x200, 0x400; 40 W beats; done.
// - len=4, addr=0xFC0: bursts awlen=1 at 0xFC0, then awlen=1 at 0x1000 (4 KB split).
// - Random awready/wready/bvalid stalls, len=20: AW/W fields stable while valid & !ready; data order matches BRAM[bram..bram+19].
//   Also: bram=510, len=4 reads BRAM 510, 511, 0, 1.
// - bresp=2'b10 on the first B of len=40: o_error=1, o_done=0, no further AW issued.
//   Next i_start clears error. len=0 start: o_done next cycle, no AXI activity.
// - Reset asserted in ST_W: all outputs 0 next edge. GDDR6_WR_SUB42_EN build: BRAM lane 0x0000002A -> wdata lane 0x00000000; lane 0x0 -> 0xFFFFFFD6.

Source files
------------

// File: rtl/bram_to_gddr6_writer.sv
// bram_to_gddr6_writer
// Reads i_length 256-bit words from a local BRAM and writes them to GDDR6
// through the AXI4 write channels of an external NAP. Each transfer is split
// into INCR bursts of at most MAX_BURST beats that never cross a 4 KB page.
// Only one burst is outstanding at a time. Everything runs on i_nap_clk.
//
// Ports
//   i_nap_clk, i_nap_reset        clock, asynchronous active-high reset
//   i_start                       1-cycle start pulse (ignored while o_busy)
//   i_gddr_addr[27:0]             GDDR6 byte address ([4:0] masked to 0)
//   i_bram_addr[8:0]              first BRAM word
//   i_length[7:0]                 beats to write, 0 = no-op
//   o_busy / o_done / o_error     status (done and error are sticky)
//   o_bram_rd_en/_addr            BRAM read port, i_bram_rd_data 1 cycle later
//   o_axi_aw*, i_axi_awready      AXI write address channel
//   o_axi_w*,  i_axi_wready       AXI write data channel
//   i_axi_b*,  o_axi_bready       AXI write response channel (bid ignored)
//   o_axi_ar*, o_axi_rready       read channels, tied off
//
// Build option
//   GDDR6_WR_SUB42_EN  when defined, each 32-bit lane of the BRAM word is
//                      written as (lane - 42) mod 2^32; otherwise passthrough.

module bram_to_gddr6_writer #(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [7:0]  AXI_ID    = 8'h1
) (
  input  logic         i_nap_clk,
  input  logic         i_nap_reset,
  input  logic         i_start,
  input  logic [27:0]  i_gddr_addr,
  input  logic [8:0]   i_bram_addr,
  input  logic [7:0]   i_length,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error,
  output logic         o_bram_rd_en,
  output logic [8:0]   o_bram_rd_addr,
  input  logic [255:0] i_bram_rd_data,
  output logic         o_axi_awvalid,
  output logic [27:0]  o_axi_awaddr,
  output logic [7:0]   o_axi_awlen,
  output logic [7:0]   o_axi_awid,
  output logic [2:0]   o_axi_awsize,
  output logic [1:0]   o_axi_awburst,
  input  logic         i_axi_awready,
  output logic         o_axi_wvalid,
  output logic [255:0] o_axi_wdata,
  output logic [31:0]  o_axi_wstrb,
  output logic         o_axi_wlast,
  input  logic         i_axi_wready,
  input  logic         i_axi_bvalid,
  output logic         o_axi_bready,
  input  logic [1:0]   i_axi_bresp,
  input  logic [7:0]   i_axi_bid,
  output logic         o_axi_arvalid,
  output logic [27:0]  o_axi_araddr,
  output logic [7:0]   o_axi_arlen,
  output logic [7:0]   o_axi_arid,
  output logic [2:0]   o_axi_arsize,
  output logic [1:0]   o_axi_arburst,
  output logic         o_axi_rready
);

  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned BRAM_AW = 9;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned LANES   = DATA_W / 32;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned BEAT_W  = 5;
  localparam int unsigned PAGE_W  = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_RD,
    ST_RDW,
    ST_W,
    ST_B,
    ST_FINISH
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_nxt;
  logic [BRAM_AW-1:0]  cur_bram, cur_bram_nxt;
  logic [LEN_W-1:0]    remaining, remaining_nxt;
  logic [BEAT_W-1:0]   blen, blen_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                done_nxt, error_nxt;
  logic [PAGE_W-1:0]   page_bytes_c;
  logic [LEN_W-1:0]    page_beats_c;
  logic [LEN_W-1:0]    blen_calc_c;

  // Read channels are never used.
  assign o_axi_arvalid = 1'b0;
  assign o_axi_araddr  = '0;
  assign o_axi_arlen   = '0;
  assign o_axi_arid    = '0;
  assign o_axi_arsize  = '0;
  assign o_axi_arburst = '0;
  assign o_axi_rready  = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, i_axi_bid, i_gddr_addr[4:0]};

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    cur_bram_nxt  = cur_bram;
    remaining_nxt = remaining;
    blen_nxt      = blen;
    beat_nxt      = beat;
    wdata_nxt     = o_axi_wdata;
    done_nxt      = o_done;
    error_nxt     = o_error;
    page_bytes_c  = '0;
    page_beats_c  = '0;
    blen_calc_c   = '0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          cur_addr_nxt  = {i_gddr_addr[27:5], 5'b0};
          cur_bram_nxt  = i_bram_addr;
          remaining_nxt = i_length;
          done_nxt      = 1'b0;
          error_nxt     = 1'b0;
          state_nxt     = (i_length == '0) ? ST_FINISH : ST_AW;
        end
      end
      ST_AW: begin
        if (i_axi_awready) begin
          beat_nxt  = '0;
          state_nxt = ST_RD;
        end
      end
      ST_RD: state_nxt = ST_RDW;
      ST_RDW: begin
`ifdef GDDR6_WR_SUB42_EN
        for (int i = 0; i < int'(LANES); i++) begin
          wdata_nxt[32*i +: 32] = i_bram_rd_data[32*i +: 32] - 32'd42;
        end
`else
        wdata_nxt = i_bram_rd_data;
`endif
        state_nxt = ST_W;
      end
      ST_W: begin
        if (i_axi_wready) begin
          cur_bram_nxt  = cur_bram + 9'd1;
          remaining_nxt = remaining - 8'd1;
          beat_nxt      = beat + 5'd1;
          state_nxt     = o_axi_wlast ? ST_B : ST_RD;
        end
      end
      ST_B: begin
        if (i_axi_bvalid) begin
          if (i_axi_bresp != 2'b00) begin
            error_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            cur_addr_nxt = cur_addr + (ADDR_W'(blen) << 5);
            state_nxt    = (remaining != '0) ? ST_AW : ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Burst size is fixed on entry to ST_AW so AW fields stay stable while waiting.
    page_bytes_c = 13'd4096 - {1'b0, cur_addr_nxt[11:0]};
    page_beats_c = LEN_W'(page_bytes_c >> 5);
    blen_calc_c  = remaining_nxt;
    if (blen_calc_c > LEN_W'(MAX_BURST)) blen_calc_c = LEN_W'(MAX_BURST);
    if (blen_calc_c > page_beats_c)      blen_calc_c = page_beats_c;
    if ((state_nxt == ST_AW) && (state != ST_AW)) blen_nxt = BEAT_W'(blen_calc_c);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_nap_clk or posedge i_nap_reset) begin
    if (i_nap_reset) begin
      state          <= ST_IDLE;
      cur_addr       <= '0;
      cur_bram       <= '0;
      remaining      <= '0;
      blen           <= '0;
      beat           <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_bram_rd_en   <= 1'b0;
      o_bram_rd_addr <= '0;
      o_axi_awvalid  <= 1'b0;
      o_axi_awaddr   <= '0;
      o_axi_awlen    <= '0;
      o_axi_awid     <= '0;
      o_axi_awsize   <= '0;
      o_axi_awburst  <= '0;
      o_axi_wvalid   <= 1'b0;
      o_axi_wdata    <= '0;
      o_axi_wstrb    <= '0;
      o_axi_wlast    <= 1'b0;
      o_axi_bready   <= 1'b0;
    end else begin
      state          <= state_nxt;
      cur_addr       <= cur_addr_nxt;
      cur_bram       <= cur_bram_nxt;
      remaining      <= remaining_nxt;
      blen           <= blen_nxt;
      beat           <= beat_nxt;
      o_busy         <= (state_nxt != ST_IDLE);
      o_done         <= done_nxt;
      o_error        <= error_nxt;
      o_bram_rd_en   <= (state_nxt == ST_RD);
      o_bram_rd_addr <= cur_bram_nxt;
      o_axi_awvalid  <= (state_nxt == ST_AW);
      o_axi_awaddr   <= cur_addr_nxt;
      o_axi_awlen    <= (state_nxt == ST_AW) ? LEN_W'(blen_nxt - 5'd1) : '0;
      o_axi_awid     <= AXI_ID;
      o_axi_awsize   <= 3'd5;
      o_axi_awburst  <= 2'b01;
      o_axi_wvalid   <= (state_nxt == ST_W);
      o_axi_wdata    <= wdata_nxt;
      o_axi_wstrb    <= '1;
      o_axi_wlast    <= (state_nxt == ST_W) && (beat_nxt == (blen_nxt - 5'd1));
      o_axi_bready   <= (state_nxt == ST_B);
    end
  end

endmodule

// File: tb/tb_bram_to_gddr6_writer.sv
module tb_bram_to_gddr6_writer;

  logic         i_nap_clk = 1'b0;
  logic         i_nap_reset = 1'b1;
  logic         i_start = 1'b0;
  logic [27:0]  i_gddr_addr = '0;
  logic [8:0]   i_bram_addr = '0;
  logic [7:0]   i_length = '0;
  logic         o_busy, o_done, o_error;
  logic         o_bram_rd_en;
  logic [8:0]   o_bram_rd_addr;
  logic [255:0] i_bram_rd_data = '0;
  logic         o_axi_awvalid;
  logic [27:0]  o_axi_awaddr;
  logic [7:0]   o_axi_awlen, o_axi_awid;
  logic [2:0]   o_axi_awsize;
  logic [1:0]   o_axi_awburst;
  logic         i_axi_awready = 1'b0;
  logic         o_axi_wvalid;
  logic [255:0] o_axi_wdata;
  logic [31:0]  o_axi_wstrb;
  logic         o_axi_wlast;
  logic         i_axi_wready = 1'b0;
  logic         i_axi_bvalid = 1'b0;
  logic         o_axi_bready;
  logic [1:0]   i_axi_bresp = 2'b00;
  logic [7:0]   i_axi_bid = 8'h1;
  logic         o_axi_arvalid;
  logic [27:0]  o_axi_araddr;
  logic [7:0]   o_axi_arlen, o_axi_arid;
  logic [2:0]   o_axi_arsize;
  logic [1:0]   o_axi_arburst;
  logic         o_axi_rready;

  bram_to_gddr6_writer dut (
    .i_nap_clk(i_nap_clk), .i_nap_reset(i_nap_reset), .i_start(i_start),
    .i_gddr_addr(i_gddr_addr), .i_bram_addr(i_bram_addr), .i_length(i_length),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_bram_rd_en(o_bram_rd_en), .o_bram_rd_addr(o_bram_rd_addr), .i_bram_rd_data(i_bram_rd_data),
    .o_axi_awvalid(o_axi_awvalid), .o_axi_awaddr(o_axi_awaddr), .o_axi_awlen(o_axi_awlen),
    .o_axi_awid(o_axi_awid), .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst),
    .i_axi_awready(i_axi_awready),
    .o_axi_wvalid(o_axi_wvalid), .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .o_axi_wlast(o_axi_wlast), .i_axi_wready(i_axi_wready),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready), .i_axi_bresp(i_axi_bresp),
    .i_axi_bid(i_axi_bid),
    .o_axi_arvalid(o_axi_arvalid), .o_axi_araddr(o_axi_araddr), .o_axi_arlen(o_axi_arlen),
    .o_axi_arid(o_axi_arid), .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
    .o_axi_rready(o_axi_rready)
  );

  always #5 i_nap_clk = ~i_nap_clk;

  typedef struct packed { logic [27:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [255:0] data; logic last; } w_t;

  aw_t          exp_aw[$];
  w_t           exp_w[$];
  logic [255:0] bram_mem [512];
  int           total = 0;
  int           bad = 0;
  bit           stall_mode = 1'b0;
  int           b_count = 0;
  int           err_at = -1;
  int           exp_bram = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endfunction

  function automatic logic [255:0] exp_word(int idx);
    logic [255:0] w;
    w = bram_mem[idx];
`ifdef GDDR6_WR_SUB42_EN
    for (int i = 0; i < 8; i++) w[32*i +: 32] = w[32*i +: 32] - 32'd42;
`endif
    return w;
  endfunction

  // One expected AW plus its len+1 W beats taken from consecutive BRAM words.
  task automatic push_aw(input logic [27:0] addr, input logic [7:0] len);
    aw_t a;
    w_t  w;
    a.addr = addr;
    a.len  = len;
    exp_aw.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      w.data = exp_word(exp_bram);
      w.last = (i == int'(len));
      exp_w.push_back(w);
      exp_bram = (exp_bram + 1) % 512;
    end
  endtask

  // Synchronous BRAM: data valid exactly one cycle after the read strobe.
  always @(posedge i_nap_clk) begin
    if (o_bram_rd_en) i_bram_rd_data <= bram_mem[o_bram_rd_addr];
    else              i_bram_rd_data <= {8{32'hDEAD_BEEF}};
  end

  // AW/W ready generators.
  always @(posedge i_nap_clk) begin
    #1;
    i_axi_awready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    i_axi_wready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // B responder; the response numbered err_at carries SLVERR.
  always @(posedge i_nap_clk) begin
    bit hs;
    hs = i_axi_bvalid && o_axi_bready;
    #1;
    if (i_nap_reset || hs) begin
      i_axi_bvalid = 1'b0;
    end else if (o_axi_bready && !i_axi_bvalid && (!stall_mode || $urandom_range(0, 2) == 0)) begin
      i_axi_bvalid = 1'b1;
      i_axi_bresp  = (b_count == err_at) ? 2'b10 : 2'b00;
      b_count++;
    end
  end

  // Monitor: pops the scoreboard on every AW/W handshake, checks hold rules.
  logic         p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic [27:0]  p_awaddr = '0;
  logic [7:0]   p_awlen = '0;
  logic [255:0] p_wdata = '0;
  logic         p_wlast = 1'b0;

  always @(negedge i_nap_clk) begin
    aw_t ea;
    w_t  ew;
    if (i_nap_reset) begin
      p_awv = 1'b0;
      p_wv  = 1'b0;
    end else begin
      if (p_awv && !p_awr) begin
        chk("aw_hold_valid", o_axi_awvalid, 1);
        chk("aw_hold_fields", {o_axi_awaddr, o_axi_awlen}, {p_awaddr, p_awlen});
      end
      if (p_wv && !p_wr) begin
        chk("w_hold_valid", o_axi_wvalid, 1);
        chk("w_hold_data", o_axi_wdata, p_wdata);
        chk("w_hold_last", o_axi_wlast, p_wlast);
      end
      if (o_axi_awvalid && i_axi_awready) begin
        if (exp_aw.size() == 0) begin
          total++; bad++;
          $display("FAIL aw_unexpected: got awaddr %h want no AW", o_axi_awaddr);
        end else begin
          ea = exp_aw.pop_front();
          chk("awaddr", o_axi_awaddr, ea.addr);
          chk("awlen", o_axi_awlen, ea.len);
          chk("aw_size_burst_id", {o_axi_awsize, o_axi_awburst, o_axi_awid}, {3'd5, 2'b01, 8'h01});
        end
      end
      if (o_axi_wvalid && i_axi_wready) begin
        if (exp_w.size() == 0) begin
          total++; bad++;
          $display("FAIL w_unexpected: got wdata %h want no W", o_axi_wdata);
        end else begin
          ew = exp_w.pop_front();
          chk("wdata", o_axi_wdata, ew.data);
          chk("wlast", o_axi_wlast, ew.last);
          chk("wstrb", o_axi_wstrb, 32'hFFFF_FFFF);
        end
      end
      p_awv = o_axi_awvalid; p_awr = i_axi_awready;
      p_awaddr = o_axi_awaddr; p_awlen = o_axi_awlen;
      p_wv = o_axi_wvalid; p_wr = i_axi_wready;
      p_wdata = o_axi_wdata; p_wlast = o_axi_wlast;
    end
  end

  task automatic do_xfer(input logic [27:0] ga, input logic [8:0] ba, input logic [7:0] ln,
                         input logic exp_done, input logic exp_err, input string tag,
                         input bit junk_start);
    int n;
    @(posedge i_nap_clk); #1;
    i_gddr_addr = ga; i_bram_addr = ba; i_length = ln; i_start = 1'b1;
    @(posedge i_nap_clk); #1;
    i_start = 1'b0;
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_done_clr"}, o_done, 0);
    chk({tag, "_err_clr"}, o_error, 0);
    n = 0;
    while (o_busy && n < 3000) begin
      if (junk_start && n == 6) begin
        i_start = 1'b1; i_gddr_addr = 28'h0AB_CDE0; i_bram_addr = 9'd300; i_length = 8'd7;
      end else begin
        i_start = 1'b0;
      end
      @(posedge i_nap_clk); #1;
      n++;
    end
    i_start = 1'b0;
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want idle", tag, n);
    end
    if (ln == 8'd0) chk({tag, "_len0_latency"}, n, 1);
    repeat (2) begin @(posedge i_nap_clk); #1; end
    chk({tag, "_done"}, o_done, exp_done);
    chk({tag, "_error"}, o_error, exp_err);
    chk({tag, "_aw_left"}, exp_aw.size(), 0);
    chk({tag, "_w_left"}, exp_w.size(), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 512; i++)
      for (int l = 0; l < 8; l++)
        bram_mem[i][32*l +: 32] = (32'(l) << 28) | (32'(i) << 8) | 32'h5A;
    bram_mem[5] = {32{8'hAA}};

    repeat (3) @(posedge i_nap_clk);
    #1;
    chk("rst_ctrl", {o_busy, o_done, o_error, o_bram_rd_en, o_axi_awvalid,
                     o_axi_wvalid, o_axi_wlast, o_axi_bready}, 0);
    chk("rst_aw", {o_axi_awaddr, o_axi_awlen, o_axi_awid, o_axi_awsize, o_axi_awburst}, 0);
    chk("rst_w", {o_axi_wstrb, o_bram_rd_addr}, 0);
    i_nap_reset = 1'b0;
    @(posedge i_nap_clk); #1;
    chk("ar_tie", {o_axi_arvalid, o_axi_araddr, o_axi_arlen, o_axi_arid,
                   o_axi_arsize, o_axi_arburst, o_axi_rready}, 0);

    // Single beat, BRAM[5] = 0xAA...
    exp_bram = 5; push_aw(28'h100, 8'd0);
    do_xfer(28'h100, 9'd5, 8'd1, 1'b1, 1'b0, "single", 1'b0);

    // 40 beats from 0: 16 + 16 + 8.
    exp_bram = 0;
    push_aw(28'h000, 8'd15); push_aw(28'h200, 8'd15); push_aw(28'h400, 8'd7);
    do_xfer(28'h000, 9'd0, 8'd40, 1'b1, 1'b0, "len40", 1'b0);

    // 4 KB page split.
    exp_bram = 50; push_aw(28'hFC0, 8'd1); push_aw(28'h1000, 8'd1);
    do_xfer(28'hFC0, 9'd50, 8'd4, 1'b1, 1'b0, "split4k", 1'b0);

    // Address wrap at 2^28.
    exp_bram = 30; push_aw(28'hFFF_FFE0, 8'd0); push_aw(28'h000_0000, 8'd0);
    do_xfer(28'hFFF_FFE0, 9'd30, 8'd2, 1'b1, 1'b0, "wrap28", 1'b0);

    // Random stalls, plus a start pulse while busy that must be ignored.
    stall_mode = 1'b1;
    exp_bram = 100; push_aw(28'h2000, 8'd15); push_aw(28'h2200, 8'd3);
    do_xfer(28'h2000, 9'd100, 8'd20, 1'b1, 1'b0, "stall20", 1'b1);
    exp_bram = 510; push_aw(28'h3000, 8'd3);
    do_xfer(28'h3000, 9'd510, 8'd4, 1'b1, 1'b0, "bramwrap", 1'b0);
    stall_mode = 1'b0;

    // SLVERR on the first B of a 40-beat transfer aborts it.
    err_at = b_count;
    exp_bram = 0; push_aw(28'h5000, 8'd15);
    do_xfer(28'h5000, 9'd0, 8'd40, 1'b0, 1'b1, "bresp_err", 1'b0);

    // Zero-length start clears the error and finishes with no AXI traffic.
    do_xfer(28'h7000, 9'd0, 8'd0, 1'b1, 1'b0, "len0", 1'b0);

    // Reset while a W beat is presented.
    exp_bram = 20; push_aw(28'h6000, 8'd3);
    @(posedge i_nap_clk); #1;
    i_gddr_addr = 28'h6000; i_bram_addr = 9'd20; i_length = 8'd4; i_start = 1'b1;
    @(posedge i_nap_clk); #1;
    i_start = 1'b0;
    n = 0;
    while (!o_axi_wvalid && n < 200) begin @(posedge i_nap_clk); #1; n++; end
    chk("mid_reach_w", o_axi_wvalid, 1);
    i_nap_reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", {o_busy, o_done, o_error, o_bram_rd_en, o_axi_awvalid,
                         o_axi_wvalid, o_axi_wlast, o_axi_bready}, 0);
    @(posedge i_nap_clk); #1;
    chk("mid_rst_edge_ctrl", {o_busy, o_done, o_error, o_bram_rd_en, o_axi_awvalid,
                              o_axi_wvalid, o_axi_wlast, o_axi_bready}, 0);
    chk("mid_rst_wdata", o_axi_wdata, 0);
    chk("mid_rst_aw", {o_axi_awaddr, o_axi_awlen, o_axi_awid, o_axi_wstrb}, 0);
    exp_aw.delete();
    exp_w.delete();
    i_nap_reset = 1'b0;

    // Recovery, with a misaligned address masked down to 0x100.
    exp_bram = 5; push_aw(28'h100, 8'd0);
    do_xfer(28'h10F, 9'd5, 8'd1, 1'b1, 1'b0, "recover", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
